// File: rtl/ddr_arb_pkg.sv
// Shared types for the DDR port arbiter.
//   arb_state_e : arbiter FSM states (idle, read in flight, write in flight, response cycle)
//   arb_op_e    : operation chosen for the granted channel
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StResp = 2'd3
  } arb_state_e;

  typedef enum logic {
    OpRd = 1'b0,
    OpWr = 1'b1
  } arb_op_e;

endpackage

// File: rtl/ddr_port_arbiter_rr.sv
// Combinational round-robin picker.
//   req_i     : per-channel request vector
//   ptr_i     : channel with highest priority this round
//   gnt_idx_o : first requesting channel at or after ptr_i, wrapping
//   any_o     : at least one request present
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            any_o
);

  int best_off;
  int off;

  always_comb begin
    best_off  = int'(N);
    off       = 0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      // Distance from ptr_i walking upward with wrap; the smallest distance wins.
      off = (i + int'(N) - int'(ptr_i)) % int'(N);
      if (req_i[i] && (off < best_off)) begin
        best_off  = off;
        gnt_idx_o = IdxW'(i);
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter from N upstream req/valid channels onto one DDR memory port.
// One transaction is in flight at a time; a per-transaction timeout aborts with an error pulse.
//   clk_i / rst_i            : clock, synchronous active-high reset
//   ch_ren_i / ch_raddr_i    : per-channel read request and address (flat buses)
//   ch_wen_i / ch_waddr_i    : per-channel write request and address
//   ch_wdata_i / ch_wmask_i  : per-channel write data and byte mask
//   ch_rdata_o               : registered read data shared by all channels
//   ch_rvalid_o/ch_wvalid_o  : one-cycle completion pulses, at most one bit set
//   ch_err_o                 : one-cycle timeout pulse alongside the aborted op's valid
//   mem_*_o                  : downstream request to the memory controller
//   mem_rdata_i/mem_rvalid_i/mem_wvalid_i : downstream responses
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned TIMEOUT  = 1024,
  parameter bit          WR_FIRST = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH-1:0]          ch_ren_i,
  input  logic [N_CH*ADDR_W-1:0]   ch_raddr_i,
  input  logic [N_CH-1:0]          ch_wen_i,
  input  logic [N_CH*ADDR_W-1:0]   ch_waddr_i,
  input  logic [N_CH*DATA_W-1:0]   ch_wdata_i,
  input  logic [N_CH*DATA_W/8-1:0] ch_wmask_i,
  output logic [DATA_W-1:0]        ch_rdata_o,
  output logic [N_CH-1:0]          ch_rvalid_o,
  output logic [N_CH-1:0]          ch_wvalid_o,
  output logic [N_CH-1:0]          ch_err_o,
  output logic                     mem_ren_o,
  output logic [ADDR_W-1:0]        mem_raddr_o,
  output logic                     mem_wen_o,
  output logic [ADDR_W-1:0]        mem_waddr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  output logic [DATA_W/8-1:0]      mem_wmask_o,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  input  logic                     mem_rvalid_i,
  input  logic                     mem_wvalid_i
);

  localparam int unsigned MaskW = DATA_W / 8;
  localparam int unsigned IdxW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   gnt_q, gnt_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MaskW-1:0]  wmask_q, wmask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [N_CH-1:0]   rvalid_q, rvalid_d;
  logic [N_CH-1:0]   wvalid_q, wvalid_d;
  logic [N_CH-1:0]   err_q, err_d;

  logic [IdxW-1:0]   arb_idx;
  logic              arb_any;
  arb_op_e           op_sel;
  logic              timeout_hit;

  rr_arbiter #(
    .N    (N_CH),
    .IdxW (IdxW)
  ) u_rr (
    .req_i     (ch_ren_i | ch_wen_i),
    .ptr_i     (ptr_q),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  // A channel asking for both ops gets one now; the other waits for its next round-robin turn.
  always_comb begin
    op_sel = OpRd;
    if (ch_wen_i[arb_idx] && (!ch_ren_i[arb_idx] || WR_FIRST)) begin
      op_sel = OpWr;
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntMax);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    wvalid_d = '0;
    err_d    = '0;

    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          gnt_d = arb_idx;
          ptr_d = (arb_idx == IdxW'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
          cnt_d = '0;
          if (op_sel == OpWr) begin
            state_d = StWr;
            addr_d  = ch_waddr_i[arb_idx*ADDR_W +: ADDR_W];
            wdata_d = ch_wdata_i[arb_idx*DATA_W +: DATA_W];
            wmask_d = ch_wmask_i[arb_idx*MaskW +: MaskW];
          end else begin
            state_d = StRd;
            addr_d  = ch_raddr_i[arb_idx*ADDR_W +: ADDR_W];
          end
        end
      end
      StRd: begin
        // A real completion on the last counted cycle wins over the timeout.
        if (mem_rvalid_i) begin
          rdata_d         = mem_rdata_i;
          rvalid_d[gnt_q] = 1'b1;
          state_d         = StResp;
        end else if (timeout_hit) begin
          rdata_d         = '0;
          rvalid_d[gnt_q] = 1'b1;
          err_d[gnt_q]    = 1'b1;
          state_d         = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWr: begin
        if (mem_wvalid_i) begin
          wvalid_d[gnt_q] = 1'b1;
          state_d         = StResp;
        end else if (timeout_hit) begin
          rdata_d         = '0;
          wvalid_d[gnt_q] = 1'b1;
          err_d[gnt_q]    = 1'b1;
          state_d         = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
      wvalid_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wvalid_q <= wvalid_d;
      err_q    <= err_d;
    end
  end

  assign mem_ren_o   = (state_q == StRd);
  assign mem_wen_o   = (state_q == StWr);
  assign mem_raddr_o = addr_q;
  assign mem_waddr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wmask_o = wmask_q;
  assign ch_rdata_o  = rdata_q;
  assign ch_rvalid_o = rvalid_q;
  assign ch_wvalid_o = wvalid_q;
  assign ch_err_o    = err_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
module tb_ddr_port_arbiter;

  localparam int unsigned N_CH     = 2;
  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned DATA_W   = 128;
  localparam int unsigned TIMEOUT  = 8;
  localparam bit          WR_FIRST = 1'b1;
  localparam int unsigned MW       = DATA_W / 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_CH-1:0]        ch_ren, ch_wen;
  logic [N_CH*ADDR_W-1:0] ch_raddr, ch_waddr;
  logic [N_CH*DATA_W-1:0] ch_wdata;
  logic [N_CH*MW-1:0]     ch_wmask;
  logic [DATA_W-1:0]      ch_rdata;
  logic [N_CH-1:0]        ch_rvalid, ch_wvalid, ch_err;
  logic                   mem_ren, mem_wen;
  logic [ADDR_W-1:0]      mem_raddr, mem_waddr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [MW-1:0]          mem_wmask;
  logic [DATA_W-1:0]      mem_rdata;
  logic                   mem_rvalid, mem_wvalid;

  ddr_port_arbiter #(
    .N_CH     (N_CH),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .TIMEOUT  (TIMEOUT),
    .WR_FIRST (WR_FIRST)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ch_ren_i     (ch_ren),
    .ch_raddr_i   (ch_raddr),
    .ch_wen_i     (ch_wen),
    .ch_waddr_i   (ch_waddr),
    .ch_wdata_i   (ch_wdata),
    .ch_wmask_i   (ch_wmask),
    .ch_rdata_o   (ch_rdata),
    .ch_rvalid_o  (ch_rvalid),
    .ch_wvalid_o  (ch_wvalid),
    .ch_err_o     (ch_err),
    .mem_ren_o    (mem_ren),
    .mem_raddr_o  (mem_raddr),
    .mem_wen_o    (mem_wen),
    .mem_waddr_o  (mem_waddr),
    .mem_wdata_o  (mem_wdata),
    .mem_wmask_o  (mem_wmask),
    .mem_rdata_i  (mem_rdata),
    .mem_rvalid_i (mem_rvalid),
    .mem_wvalid_i (mem_wvalid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester-side model: what each channel is asking for, plus expected shared state.
  bit                pend_r [N_CH];
  bit                pend_w [N_CH];
  logic [ADDR_W-1:0] m_raddr[N_CH];
  logic [ADDR_W-1:0] m_waddr[N_CH];
  logic [DATA_W-1:0] m_wdata[N_CH];
  logic [MW-1:0]     m_wmask[N_CH];
  int                m_ptr;
  logic [DATA_W-1:0] m_rdata;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < N_CH; i++) begin
      ch_ren[i]                      = pend_r[i];
      ch_wen[i]                      = pend_w[i];
      ch_raddr[i*ADDR_W +: ADDR_W]   = m_raddr[i];
      ch_waddr[i*ADDR_W +: ADDR_W]   = m_waddr[i];
      ch_wdata[i*DATA_W +: DATA_W]   = m_wdata[i];
      ch_wmask[i*MW +: MW]           = m_wmask[i];
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic add_req(input int c, input bit rd, input bit wr);
    if (rd && !pend_r[c]) begin
      pend_r[c]  = 1'b1;
      m_raddr[c] = {$urandom, $urandom};
    end
    if (wr && !pend_w[c]) begin
      pend_w[c]  = 1'b1;
      m_waddr[c] = {$urandom, $urandom};
      m_wdata[c] = rnd128();
      m_wmask[c] = MW'($urandom);
    end
    drive();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    mem_rvalid = 1'b0;
    mem_wvalid = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      pend_r[i] = 1'b0;
      pend_w[i] = 1'b0;
    end
    drive();
    tick();
    tick();
    rst     = 1'b0;
    m_ptr   = 0;
    m_rdata = '0;
  endtask

  // Next grant: first channel with anything pending, scanning from the pointer with wrap.
  function automatic int exp_grant();
    for (int k = 0; k < N_CH; k++) begin
      int c;
      c = (m_ptr + k) % N_CH;
      if (pend_r[c] || pend_w[c]) return c;
    end
    return -1;
  endfunction

  // Serve one transaction. DUT must be idle on entry with at least one request pending.
  task automatic run_op(input int lat, input bit no_resp, input bit stray,
                        input logic [DATA_W-1:0] rdv);
    int g, n, waited;
    bit wr, seen;
    logic [N_CH-1:0] onehot;
    g      = exp_grant();
    wr     = pend_w[g] && (!pend_r[g] || WR_FIRST);
    onehot = N_CH'(1) << g;
    m_ptr  = (g + 1) % N_CH;
    seen   = 1'b0;
    waited = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      waited++;
      seen = mem_ren | mem_wen;
    end
    chk("req_latency", waited, 1);
    if (!seen) return;
    chk("mem_op", {mem_ren, mem_wen}, wr ? 2'b01 : 2'b10);
    if (wr) begin
      chk("mem_waddr", mem_waddr, m_waddr[g]);
      chk("mem_wdata", mem_wdata, m_wdata[g]);
      chk("mem_wmask", mem_wmask, m_wmask[g]);
    end else begin
      chk("mem_raddr", mem_raddr, m_raddr[g]);
    end
    if (no_resp) begin
      n = 1;
      for (int i = 0; i < 4 * TIMEOUT; i++) begin
        tick();
        if (!(mem_ren | mem_wen)) break;
        n++;
      end
      chk("timeout_len", n, TIMEOUT);
      m_rdata = '0;
    end else begin
      for (int i = 0; i < lat; i++) begin
        if (stray && i == 0) begin
          if (wr) mem_rvalid = 1'b1;
          else mem_wvalid = 1'b1;
        end
        tick();
        mem_rvalid = 1'b0;
        mem_wvalid = 1'b0;
        chk("held_req", mem_ren | mem_wen, 1'b1);
      end
      mem_rdata = rdv;
      if (wr) mem_wvalid = 1'b1;
      else mem_rvalid = 1'b1;
      tick();
      mem_rvalid = 1'b0;
      mem_wvalid = 1'b0;
      mem_rdata  = rnd128();
      if (!wr) m_rdata = rdv;
    end
    chk("rvalid_pulse", ch_rvalid, wr ? '0 : onehot);
    chk("wvalid_pulse", ch_wvalid, wr ? onehot : '0);
    chk("err_pulse", ch_err, no_resp ? onehot : '0);
    chk("rdata", ch_rdata, m_rdata);
    chk("mem_idle_resp", {mem_ren, mem_wen}, 2'b00);
    if (wr) pend_w[g] = 1'b0;
    else pend_r[g] = 1'b0;
    drive();
    // A stray response during the response cycle must be dropped.
    mem_rvalid = 1'($urandom);
    mem_rdata  = rnd128();
    tick();
    mem_rvalid = 1'b0;
    chk("pulse_clear", {ch_rvalid, ch_wvalid, ch_err}, '0);
    chk("rdata_hold", ch_rdata, m_rdata);
  endtask

  initial begin
    int ch, kind;
    #100000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ch, kind;
    for (int i = 0; i < N_CH; i++) begin
      m_raddr[i] = '0;
      m_waddr[i] = '0;
      m_wdata[i] = '0;
      m_wmask[i] = '0;
    end
    mem_rdata = '0;
    do_reset();

    // Reset state
    chk("rst_rvalid", ch_rvalid, '0);
    chk("rst_wvalid", ch_wvalid, '0);
    chk("rst_err", ch_err, '0);
    chk("rst_rdata", ch_rdata, '0);
    chk("rst_mem_en", {mem_ren, mem_wen}, 2'b00);
    chk("rst_mem_addr", {mem_raddr, mem_waddr}, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_mem_wmask", mem_wmask, '0);

    // Single read from ch0
    pend_r[0]  = 1'b1;
    m_raddr[0] = 64'h80;
    drive();
    run_op(2, 1'b0, 1'b0, {16{8'hA5}});
    chk("single_rdata", ch_rdata, {16{8'hA5}});

    // Contention from a fresh pointer: 0,1,0,1
    do_reset();
    add_req(0, 1'b1, 1'b0);
    add_req(1, 1'b1, 1'b0);
    run_op(1, 1'b0, 1'b0, rnd128());
    add_req(0, 1'b1, 1'b0);
    run_op(0, 1'b0, 1'b0, rnd128());
    add_req(1, 1'b1, 1'b0);
    run_op(3, 1'b0, 1'b0, rnd128());
    run_op(2, 1'b0, 1'b0, rnd128());

    // Read/write tie on ch1: write first with mask 0x00FF, then the read
    do_reset();
    add_req(1, 1'b1, 1'b1);
    m_wmask[1] = 16'h00FF;
    drive();
    run_op(1, 1'b0, 1'b0, rnd128());
    run_op(1, 1'b0, 1'b0, rnd128());

    // Timeout on a read
    add_req(0, 1'b1, 1'b0);
    run_op(0, 1'b1, 1'b0, '0);

    // Reset in the middle of a read; the late response must be dropped
    add_req(1, 1'b1, 1'b0);
    tick();
    tick();
    chk("midop_mem_ren", mem_ren, 1'b1);
    do_reset();
    mem_rdata  = rnd128();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("midop_no_pulse", {ch_rvalid, ch_wvalid, ch_err}, '0);
    chk("midop_rdata", ch_rdata, '0);
    chk("midop_mem_idle", {mem_ren, mem_wen}, 2'b00);
    add_req(0, 1'b1, 1'b0);
    add_req(1, 1'b0, 1'b1);
    run_op(1, 1'b0, 1'b0, rnd128());
    run_op(1, 1'b0, 1'b0, rnd128());

    // Stray write-valid during a read
    add_req(0, 1'b1, 1'b0);
    run_op(3, 1'b0, 1'b1, rnd128());

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!pend_r[c] && !pend_w[c] && ($urandom % 2 == 0)) begin
          kind = int'($urandom % 3);
          add_req(c, kind != 1, kind != 0);
        end
      end
      if (exp_grant() < 0) begin
        ch = int'($urandom % N_CH);
        add_req(ch, 1'b1, 1'b0);
      end
      run_op(int'($urandom % 6), ($urandom % 8) == 0, ($urandom % 4) == 0, rnd128());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
